// File: rtl/fire_control.sv
// Turn-based firing controller: aim, charge power while fire is held, launch on release,
// track the shot until it lands, hits or times out, then hand the turn to the other tank.
module fire_control #(
   parameter int unsigned POWER_MIN      = 4,
   parameter int unsigned POWER_MAX      = 15,
   parameter int unsigned CHARGE_DIV     = 4,
   parameter int unsigned ARM_FRAMES     = 2,
   parameter int unsigned FLIGHT_TIMEOUT = 255,
   parameter int unsigned SETTLE_FRAMES  = 30,
   parameter int unsigned X_MAX          = 639,
   parameter int unsigned Y_MAX          = 479,
   parameter int unsigned B_SIZE         = 3
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic       fire_key,
   input  logic       aim_valid,
   input  logic [1:0] aim_dir,
   input  logic       hit,
   input  logic [9:0] BulletX,
   input  logic [9:0] BulletY,
   output logic       shoot,
   output logic [9:0] y_component,
   output logic [1:0] Direction,
   output logic [1:0] currentTank,
   output logic [3:0] power,
   output logic       busy,
   output logic       hit_valid
);

   typedef enum logic [2:0] {StIdle, StCharge, StFire, StFlight, StSettle} state_e;

   localparam logic [3:0] PMin       = 4'(POWER_MIN);
   localparam logic [3:0] PMax       = 4'(POWER_MAX);
   localparam logic [7:0] DivLast    = 8'(CHARGE_DIV - 1);
   localparam logic [7:0] ArmCnt     = 8'(ARM_FRAMES);
   localparam logic [7:0] TimeoutCnt = 8'(FLIGHT_TIMEOUT);
   localparam logic [7:0] SettleLast = 8'(SETTLE_FRAMES - 1);

   localparam logic signed [10:0] XMax  = 11'(X_MAX);
   localparam logic signed [10:0] YMax  = 11'(Y_MAX);
   localparam logic signed [10:0] BSize = 11'(B_SIZE);

   state_e     state_q;
   logic       armed_q;
   logic [7:0] div_cnt_q;
   logic [7:0] cnt_q;   // flight frame count, reused as settle frame count

   logic signed [10:0] bx, by;
   logic               landed, detect_en, aim_ok;

   // Signed 11-bit so that positions below B_SIZE wrap negative and count as landed.
   assign bx = signed'({1'b0, BulletX});
   assign by = signed'({1'b0, BulletY});

   assign landed = (by + BSize >= YMax) || (by - BSize <= 11'sd0) ||
                   (bx + BSize >= XMax) || (bx - BSize <= 11'sd0);

   assign detect_en   = (cnt_q >= ArmCnt);
   assign aim_ok      = aim_valid && !aim_dir[1];
   assign y_component = ~{6'b0, power} + 10'd1;

   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         state_q     <= StIdle;
         shoot       <= 1'b0;
         power       <= PMin;
         Direction   <= 2'b01;
         currentTank <= 2'b00;
         busy        <= 1'b0;
         hit_valid   <= 1'b0;
         armed_q     <= 1'b0;
         div_cnt_q   <= 8'd0;
         cnt_q       <= 8'd0;
      end else begin
         shoot     <= 1'b0;
         hit_valid <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (aim_ok) Direction <= aim_dir;
               if (!fire_key) begin
                  armed_q <= 1'b1;
               end else if (armed_q) begin
                  state_q   <= StCharge;
                  power     <= PMin;
                  div_cnt_q <= 8'd0;
               end
            end
            StCharge: begin
               if (aim_ok) Direction <= aim_dir;
               if (fire_key) begin
                  if (div_cnt_q == DivLast) begin
                     div_cnt_q <= 8'd0;
                     if (power < PMax) power <= power + 4'd1;
                  end else begin
                     div_cnt_q <= div_cnt_q + 8'd1;
                  end
               end else begin
                  state_q <= StFire;
                  shoot   <= 1'b1;
                  busy    <= 1'b1;
               end
            end
            StFire: begin
               state_q <= StFlight;
               cnt_q   <= 8'd0;
            end
            StFlight: begin
               // A hit wins over a simultaneous boundary crossing.
               if (detect_en && hit) begin
                  hit_valid <= 1'b1;
                  state_q   <= StSettle;
                  cnt_q     <= 8'd0;
               end else if ((detect_en && landed) || (cnt_q == TimeoutCnt)) begin
                  state_q <= StSettle;
                  cnt_q   <= 8'd0;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            StSettle: begin
               if (cnt_q == SettleLast) begin
                  currentTank <= {1'b0, ~currentTank[0]};
                  Direction   <= currentTank[0] ? 2'b01 : 2'b00;
                  power       <= PMin;
                  busy        <= 1'b0;
                  armed_q     <= 1'b0;
                  state_q     <= StIdle;
                  cnt_q       <= 8'd0;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_fire_control.sv
// Bench for fire_control: randomized turns checked against a frame-level model of each turn.
module tb_fire_control;

   localparam int POWER_MIN      = 4;
   localparam int POWER_MAX      = 15;
   localparam int CHARGE_DIV     = 4;
   localparam int ARM_FRAMES     = 2;
   localparam int FLIGHT_TIMEOUT = 255;
   localparam int SETTLE_FRAMES  = 30;

   logic       frame_clk = 1'b0;
   logic       Reset = 1'b1;
   logic       fire_key = 1'b0;
   logic       aim_valid = 1'b0;
   logic [1:0] aim_dir = 2'b00;
   logic       hit = 1'b0;
   logic [9:0] BulletX = 10'd320;
   logic [9:0] BulletY = 10'd240;
   logic       shoot, busy, hit_valid;
   logic [9:0] y_component;
   logic [1:0] Direction, currentTank;
   logic [3:0] power;

   int checks = 0;
   int errors = 0;

   // Model state
   logic [1:0] m_dir  = 2'b01;
   logic [1:0] m_tank = 2'b00;
   int         m_power = POWER_MIN;

   fire_control dut (
      .frame_clk  (frame_clk),
      .Reset      (Reset),
      .fire_key   (fire_key),
      .aim_valid  (aim_valid),
      .aim_dir    (aim_dir),
      .hit        (hit),
      .BulletX    (BulletX),
      .BulletY    (BulletY),
      .shoot      (shoot),
      .y_component(y_component),
      .Direction  (Direction),
      .currentTank(currentTank),
      .power      (power),
      .busy       (busy),
      .hit_valid  (hit_valid)
   );

   always #5 frame_clk = ~frame_clk;

   task automatic tick();
      @(posedge frame_clk);
      #1;
   endtask

   function automatic logic [9:0] neg10(input int p);
      return 10'(-p);
   endfunction

   task automatic drive_safe();
      BulletX = 10'($urandom_range(635, 4));
      BulletY = 10'($urandom_range(475, 4));
   endtask

   task automatic drive_land(input int kind);
      drive_safe();
      case (kind)
         0:       BulletY = 10'($urandom_range(479, 476));
         1:       BulletY = 10'($urandom_range(3, 0));
         2:       BulletX = 10'($urandom_range(639, 636));
         default: BulletX = 10'($urandom_range(3, 0));
      endcase
   endtask

   task automatic drive_aim(input bit accept);
      aim_valid = 1'($urandom_range(1, 0));
      aim_dir   = 2'($urandom_range(3, 0));
      if (accept && aim_valid && aim_dir <= 2'd1) m_dir = aim_dir;
   endtask

   // Arms in IDLE, holds fire for 'press' frames, releases; ends with the DUT in FLIGHT frame 0.
   task automatic charge_and_fire(input int press, input string tag);
      fire_key = 1'b0; hit = 1'b0; drive_safe(); drive_aim(1'b1);
      tick();
      for (int i = 0; i < press; i++) begin
         fire_key = 1'b1; drive_aim(1'b1);
         tick();
         checks++;
         if (shoot !== 1'b0 || busy !== 1'b0 || Direction !== m_dir) begin
            errors++;
            $display("FAIL %s charge frame %0d: shoot=%b busy=%b dir=%b, want 0 0 %b",
                     tag, i, shoot, busy, Direction, m_dir);
         end
      end
      m_power = POWER_MIN + (press - 1) / CHARGE_DIV;
      if (m_power > POWER_MAX) m_power = POWER_MAX;
      fire_key = 1'b0; aim_valid = 1'b0;
      tick();
      checks++;
      if (shoot !== 1'b1 || busy !== 1'b1 || power !== 4'(m_power) ||
          y_component !== neg10(m_power)) begin
         errors++;
         $display("FAIL %s launch: shoot=%b busy=%b power=%0d y=%h, want 1 1 %0d %h",
                  tag, shoot, busy, power, y_component, m_power, neg10(m_power));
      end
      tick();
      checks++;
      if (shoot !== 1'b0 || busy !== 1'b1 || power !== 4'(m_power)) begin
         errors++;
         $display("FAIL %s after launch: shoot=%b busy=%b power=%0d, want 0 1 %0d",
                  tag, shoot, busy, power, m_power);
      end
   endtask

   // Drives the flight (hit/landing at given flight frames, -1 = never), then the settle period.
   task automatic fly_and_settle(input int hit_at, input int land_at, input int kind,
                                 input bit hold_key, input string tag);
      int exit_c;
      bit exp_hit;
      exit_c = FLIGHT_TIMEOUT;
      if (land_at >= ARM_FRAMES && land_at < exit_c) exit_c = land_at;
      if (hit_at >= ARM_FRAMES && hit_at <= exit_c) exit_c = hit_at;
      exp_hit = (hit_at == exit_c);
      for (int c = 0; c <= exit_c; c++) begin
         hit = (c == hit_at);
         if (c == land_at) drive_land(kind); else drive_safe();
         drive_aim(1'b0);
         tick();
         checks++;
         if (c < exit_c) begin
            if (hit_valid !== 1'b0 || busy !== 1'b1 || shoot !== 1'b0 ||
                Direction !== m_dir || currentTank !== m_tank ||
                y_component !== neg10(m_power)) begin
               errors++;
               $display("FAIL %s flight %0d: hv=%b busy=%b shoot=%b dir=%b tank=%0d y=%h",
                        tag, c, hit_valid, busy, shoot, Direction, currentTank, y_component);
            end
         end else if (hit_valid !== exp_hit || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s landing at %0d: hit_valid=%b busy=%b, want %b 1",
                     tag, c, hit_valid, busy, exp_hit);
         end
      end
      hit = 1'b0; aim_valid = 1'b0; fire_key = hold_key; drive_safe();
      for (int s = 1; s < SETTLE_FRAMES; s++) begin
         tick();
         checks++;
         if (hit_valid !== 1'b0 || busy !== 1'b1 || currentTank !== m_tank ||
             shoot !== 1'b0) begin
            errors++;
            $display("FAIL %s settle %0d: hv=%b busy=%b tank=%0d shoot=%b, want 0 1 %0d 0",
                     tag, s, hit_valid, busy, currentTank, shoot, m_tank);
         end
      end
      tick();
      m_tank  = (m_tank == 2'd0) ? 2'd1 : 2'd0;
      m_dir   = (m_tank == 2'd0) ? 2'b01 : 2'b00;
      m_power = POWER_MIN;
      checks++;
      if (busy !== 1'b0 || currentTank !== m_tank || Direction !== m_dir ||
          power !== 4'(POWER_MIN) || y_component !== neg10(POWER_MIN) || hit_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s turn switch: busy=%b tank=%0d dir=%b power=%0d, want 0 %0d %b %0d",
                  tag, busy, currentTank, Direction, power, m_tank, m_dir, POWER_MIN);
      end
   endtask

   task automatic check_reset_values(input string tag);
      checks++;
      if (shoot !== 1'b0 || power !== 4'(POWER_MIN) || y_component !== 10'h3FC ||
          Direction !== 2'b01 || currentTank !== 2'b00 || busy !== 1'b0 ||
          hit_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s: shoot=%b power=%0d y=%h dir=%b tank=%0d busy=%b hv=%b",
                  tag, shoot, power, y_component, Direction, currentTank, busy, hit_valid);
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1; fire_key = 1'b1;
      tick();
      check_reset_values("reset");
      Reset = 1'b0;
      m_tank = 2'd0; m_dir = 2'b01; m_power = POWER_MIN;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (shoot !== 1'b0 || busy !== 1'b0 || currentTank !== 2'd0 ||
             Direction !== 2'b01 || power !== 4'(POWER_MIN)) begin
            errors++;
            $display("FAIL held_key_after_reset %0d: shoot=%b busy=%b tank=%0d dir=%b pwr=%0d",
                     i, shoot, busy, currentTank, Direction, power);
         end
      end
   endtask

   task automatic test_charge_and_land();
      charge_and_fire(9, "charge9");
      checks++;
      if (power !== 4'd6 || y_component !== 10'h3FA) begin
         errors++;
         $display("FAIL charge9 power: power=%0d y=%h, want 6 3fa", power, y_component);
      end
      fly_and_settle(-1, 5, 0, 1'b0, "land_bottom");
   endtask

   task automatic test_saturation_hit_and_edge();
      charge_and_fire(80, "charge80");
      checks++;
      if (power !== 4'd15 || y_component !== 10'h3F1) begin
         errors++;
         $display("FAIL charge80 power: power=%0d y=%h, want 15 3f1", power, y_component);
      end
      fly_and_settle(7, 7, 2, 1'b0, "hit_plus_edge");
   endtask

   task automatic test_timeout();
      charge_and_fire(int'($urandom_range(20, 1)), "charge_to");
      fly_and_settle(1, 0, 1, 1'b0, "timeout");
   endtask

   task automatic test_hold_through_settle();
      charge_and_fire(int'($urandom_range(20, 1)), "charge_hold");
      fly_and_settle(3, -1, 0, 1'b1, "settle_held");
      fire_key = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if (shoot !== 1'b0 || busy !== 1'b0 || power !== 4'(POWER_MIN)) begin
            errors++;
            $display("FAIL held_after_settle %0d: shoot=%b busy=%b power=%0d, want 0 0 %0d",
                     i, shoot, busy, power, POWER_MIN);
         end
      end
      fire_key = 1'b0;
      tick();
      checks++;
      if (shoot !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL release_after_held: shoot=%b busy=%b, want 0 0", shoot, busy);
      end
   endtask

   task automatic test_random_turns();
      for (int t = 0; t < 8; t++) begin
         charge_and_fire(int'($urandom_range(40, 1)), "rand_charge");
         fly_and_settle(int'($urandom_range(20, 0)) - 1, int'($urandom_range(20, 0)) - 1,
                        int'($urandom_range(3, 0)), 1'b0, "rand_flight");
      end
   endtask

   task automatic test_reset_mid_flight();
      charge_and_fire(int'($urandom_range(30, 1)), "charge_rst");
      for (int i = 0; i < 3; i++) begin
         drive_safe(); hit = 1'b0;
         tick();
      end
      Reset = 1'b1;
      tick();
      check_reset_values("reset_mid_flight");
      Reset = 1'b0;
      m_tank = 2'd0; m_dir = 2'b01; m_power = POWER_MIN;
      tick();
      check_reset_values("after_reset_mid_flight");
   endtask

   initial begin
      test_reset();
      test_charge_and_land();
      test_saturation_hit_and_edge();
      test_timeout();
      test_hold_through_settle();
      test_random_turns();
      test_reset_mid_flight();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fire_control.md
Name: fire_control

Overview:
- Turn-based firing controller for the artillery tank game; drives the projectile block's launch interface (shoot, Direction, y_component, currentTank) and watches its position to detect when the shot ends.
- Sequence per turn: aim, charge power while the fire key is held, launch on release, track flight until landing/hit/timeout, settle, hand turn to the other tank.
- Sits between the keycode decode logic and the bullet/collision/HUD logic; clocked by the frame clock.

Parameters:
- POWER_MIN, 4, initial power at charge start (frames-units of upward speed).
- POWER_MAX, 15, saturation value of power.
- CHARGE_DIV, 4, frames per power increment while charging.
- ARM_FRAMES, 2, frames after launch during which landing detection is ignored.
- FLIGHT_TIMEOUT, 255, max flight frames before forced landing.
- SETTLE_FRAMES, 30, frames between landing and turn switch.
- X_MAX, 639; Y_MAX, 479; B_SIZE, 3: playfield bounds and bullet half-size.

Ports:
- frame_clk  in  1   sole clock.
- Reset  in  1   synchronous, active-high reset.
- fire_key  in  1   level, high while fire key held.
- aim_valid  in  1   qualifies aim_dir this frame.
- aim_dir  in  2   requested facing: 00 left, 01 right; 10/11 ignored.
- hit  in  1   collision detector: bullet overlaps a tank this frame.
- BulletX  in  10  bullet X position.
- BulletY  in  10  bullet Y position.
- shoot  out  1   one-frame launch pulse.
- y_component  out  10  initial vertical velocity, two's complement, = -power.
- Direction  out  2   current facing.
- currentTank  out  2   active tank, 0 or 1.
- power  out  4   charge level for HUD.
- busy  out  1   high from launch until turn switch.
- hit_valid  out  1   one-frame pulse when shot ends on a hit.

Behaviour:
- Everything updates on posedge frame_clk only. Reset (sync) has priority over all else. It yields: state IDLE, shoot 0, power POWER_MIN, y_component = -POWER_MIN (10'h3FC), Direction 01, currentTank 0, busy 0, hit_valid 0, armed 0, counters 0.
- States: IDLE, CHARGE, FIRE, FLIGHT, SETTLE.
- IDLE:
  - armed is set when fire_key == 0 is sampled. This prevents a key held across reset or a turn change from auto-firing.
  - aim_valid with aim_dir 00/01 loads Direction next edge. 10/11 leaves Direction unchanged.
  - fire_key == 1 && armed: go to CHARGE, power = POWER_MIN, div counter = 0.
- CHARGE:
  - aim updates are still accepted.
  - While fire_key == 1, the div counter increments. At CHARGE_DIV-1 it wraps to 0, and power increments with saturation at POWER_MAX.
  - fire_key == 0: go to FIRE. power freezes.
- FIRE (exactly 1 frame):
  - shoot = 1 and busy = 1. y_component is already valid (the bullet samples it on this edge).
  - Then go to FLIGHT with the flight counter = 0.
- FLIGHT:
  - shoot = 0. The flight counter increments each frame.
  - Aim input is ignored. Direction, y_component and currentTank are held stable.
  - Detection is enabled once the counter >= ARM_FRAMES.
  - Landing condition (any of): BulletY + B_SIZE >= Y_MAX, BulletY - B_SIZE <= 0, BulletX + B_SIZE >= X_MAX, BulletX - B_SIZE <= 0.
  - hit == 1 while enabled: hit_valid = 1 for one frame, go to SETTLE. If hit and boundary occur in the same frame, it is treated as a hit; there is one landing only.
  - Landing condition without hit: go to SETTLE, hit_valid stays 0.
  - Counter == FLIGHT_TIMEOUT: go to SETTLE (forced landing).
- SETTLE:
  - Counts SETTLE_FRAMES frames.
  - On the final frame: currentTank toggles 0 <-> 1, and Direction defaults to 01 for tank 0 and 00 for tank 1.
  - Also on the final frame: power = POWER_MIN, busy = 0, armed = 0, go to IDLE.
- Output rules:
  - y_component = (~{6'b0,power}) + 1, i.e. 10-bit sign extension of -power, and is continuous.
  - shoot is never asserted outside FIRE.
  - hit_valid is never asserted outside the FLIGHT -> SETTLE edge.
- Boundary conditions:
  - Reset in any state returns all outputs to their reset values on that edge.
  - fire_key held through all of SETTLE: no charge starts until the key is released and pressed again.
  - Subtraction underflow: the compare BulletY - B_SIZE <= 0 is done in 11-bit signed width, so BulletY < 3 counts as landed.

Test Plan:
- Reset, fire_key held high 10 frames -> state stays IDLE, shoot 0, currentTank 0, Direction 01.
- Release then press fire_key for 9 frames, release (CHARGE_DIV 4) -> power = 6, y_component = 10'h3FA, single shoot pulse on the frame after release, busy rises the same frame.
- Press 80 frames -> power saturates at 15, y_component = 10'h3F1.
- FLIGHT with BulletY driven to 477 at flight frame 5 -> SETTLE, hit_valid 0; after 30 frames currentTank = 1, Direction = 00, busy 0.
- hit = 1 and BulletX = 637 in the same frame -> exactly one hit_valid pulse, one transition to SETTLE.
- hit = 1 at flight frame 1 (before ARM_FRAMES) -> ignored. No landing for 255 frames -> timeout to SETTLE. Reset mid-FLIGHT -> all outputs at reset values next edge.
